// File: rtl/wfg_stim_mem_arb_if.sv
// Bus bundle between two stim read channels, a host port and one single-port SRAM.
interface wfg_stim_mem_arb_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              ch0_req_i;
    logic [ADDR_W-1:0] ch0_addr_i;
    logic              ch0_gnt_o;
    logic              ch0_rvalid_o;
    logic [DATA_W-1:0] ch0_rdata_o;

    logic              ch1_req_i;
    logic [ADDR_W-1:0] ch1_addr_i;
    logic              ch1_gnt_o;
    logic              ch1_rvalid_o;
    logic [DATA_W-1:0] ch1_rdata_o;

    logic              host_req_i;
    logic              host_we_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [DATA_W-1:0] host_wdata_i;
    logic [MASK_W-1:0] host_wmask_i;
    logic              host_gnt_o;
    logic              host_rvalid_o;
    logic [DATA_W-1:0] host_rdata_o;

    logic              csb0_o;
    logic              web0_o;
    logic [MASK_W-1:0] wmask0_o;
    logic [ADDR_W-1:0] addr0_o;
    logic [DATA_W-1:0] din0_o;
    logic [DATA_W-1:0] dout0_i;

    // Arbiter side
    modport slave (
        input  ch0_req_i, ch0_addr_i,
        output ch0_gnt_o, ch0_rvalid_o, ch0_rdata_o,
        input  ch1_req_i, ch1_addr_i,
        output ch1_gnt_o, ch1_rvalid_o, ch1_rdata_o,
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i, host_wmask_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o,
        output csb0_o, web0_o, wmask0_o, addr0_o, din0_o,
        input  dout0_i
    );

    // Requesters and SRAM side
    modport master (
        output ch0_req_i, ch0_addr_i,
        input  ch0_gnt_o, ch0_rvalid_o, ch0_rdata_o,
        output ch1_req_i, ch1_addr_i,
        input  ch1_gnt_o, ch1_rvalid_o, ch1_rdata_o,
        output host_req_i, host_we_i, host_addr_i, host_wdata_i, host_wmask_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o,
        input  csb0_o, web0_o, wmask0_o, addr0_o, din0_o,
        output dout0_i
    );
endinterface

// File: rtl/wfg_stim_mem_arb.sv
// Single-port SRAM arbiter for two stim read channels and a host port, 1-cycle read return.
// WFG_MEM_ARB_HOST_PRIO_EN: host strict priority; otherwise 3-way round robin ch0->ch1->host.
module wfg_stim_mem_arb #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    wfg_stim_mem_arb_if.slave bus
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned NSRC   = 3;
`ifdef WFG_MEM_ARB_HOST_PRIO_EN
    localparam int unsigned RR_W   = 1;
`else
    localparam int unsigned RR_W   = 2;
`endif
    localparam logic [1:0] SRC_CH0  = 2'd0;
    localparam logic [1:0] SRC_CH1  = 2'd1;
    localparam logic [1:0] SRC_HOST = 2'd2;

    logic [RR_W-1:0]   rr_q, rr_d;
    logic              tag_vld_q, tag_vld_d;
    logic [1:0]        tag_src_q, tag_src_d;
    logic [NSRC-1:0]   req_c, gnt_c, rvalid_c;
    logic              csb_c, web_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] din_c;
    logic [MASK_W-1:0] wmask_c;

    // Nothing is accepted while reset is asserted
    assign req_c = {bus.host_req_i, bus.ch1_req_i, bus.ch0_req_i} & {NSRC{rst_n}};

`ifdef WFG_MEM_ARB_HOST_PRIO_EN
    // Host first, then the two channels alternate on rr_q
    always_comb begin
        gnt_c = '0;
        rr_d  = rr_q;
        if (req_c[SRC_HOST]) begin
            gnt_c[SRC_HOST] = 1'b1;
        end else if (req_c[SRC_CH0] && (!req_c[SRC_CH1] || rr_q == 1'b0)) begin
            gnt_c[SRC_CH0] = 1'b1;
            rr_d           = 1'b1;
        end else if (req_c[SRC_CH1]) begin
            gnt_c[SRC_CH1] = 1'b1;
            rr_d           = 1'b0;
        end
    end
`else
    logic [1:0] cand;
    logic       found;

    // Search from the favoured source; pointer moves past the winner
    always_comb begin
        gnt_c = '0;
        rr_d  = rr_q;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            cand = 2'((32'(rr_q) + k) % NSRC);
            if (!found && req_c[cand]) begin
                found       = 1'b1;
                gnt_c[cand] = 1'b1;
                rr_d        = (cand == SRC_HOST) ? SRC_CH0 : cand + 2'd1;
            end
        end
    end
`endif

    // SRAM port drive and read-return tag for the next cycle
    always_comb begin
        csb_c     = 1'b1;
        web_c     = 1'b1;
        addr_c    = '0;
        din_c     = '0;
        wmask_c   = '0;
        tag_vld_d = 1'b0;
        tag_src_d = SRC_CH0;
        if (gnt_c[SRC_CH0]) begin
            csb_c     = 1'b0;
            addr_c    = bus.ch0_addr_i;
            tag_vld_d = 1'b1;
            tag_src_d = SRC_CH0;
        end else if (gnt_c[SRC_CH1]) begin
            csb_c     = 1'b0;
            addr_c    = bus.ch1_addr_i;
            tag_vld_d = 1'b1;
            tag_src_d = SRC_CH1;
        end else if (gnt_c[SRC_HOST]) begin
            csb_c  = 1'b0;
            addr_c = bus.host_addr_i;
            if (bus.host_we_i) begin
                web_c   = 1'b0;
                din_c   = bus.host_wdata_i;
                wmask_c = bus.host_wmask_i;
            end else begin
                tag_vld_d = 1'b1;
                tag_src_d = SRC_HOST;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            tag_vld_q <= 1'b0;
            tag_src_q <= SRC_CH0;
        end else begin
            rr_q      <= rr_d;
            tag_vld_q <= tag_vld_d;
            tag_src_q <= tag_src_d;
        end
    end

    assign rvalid_c[SRC_CH0]  = tag_vld_q && (tag_src_q == SRC_CH0);
    assign rvalid_c[SRC_CH1]  = tag_vld_q && (tag_src_q == SRC_CH1);
    assign rvalid_c[SRC_HOST] = tag_vld_q && (tag_src_q == SRC_HOST);

    assign bus.ch0_gnt_o     = gnt_c[SRC_CH0];
    assign bus.ch1_gnt_o     = gnt_c[SRC_CH1];
    assign bus.host_gnt_o    = gnt_c[SRC_HOST];
    assign bus.ch0_rvalid_o  = rvalid_c[SRC_CH0];
    assign bus.ch1_rvalid_o  = rvalid_c[SRC_CH1];
    assign bus.host_rvalid_o = rvalid_c[SRC_HOST];
    assign bus.ch0_rdata_o   = rvalid_c[SRC_CH0]  ? bus.dout0_i : '0;
    assign bus.ch1_rdata_o   = rvalid_c[SRC_CH1]  ? bus.dout0_i : '0;
    assign bus.host_rdata_o  = rvalid_c[SRC_HOST] ? bus.dout0_i : '0;

    assign bus.csb0_o   = csb_c;
    assign bus.web0_o   = web_c;
    assign bus.addr0_o  = addr_c;
    assign bus.din0_o   = din_c;
    assign bus.wmask0_o = wmask_c;
endmodule

// File: tb/tb_wfg_stim_mem_arb.sv
// Directed bench for wfg_stim_mem_arb with a behavioural 1-cycle-latency SRAM.
module tb_wfg_stim_mem_arb;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [2:0]        t4_req [3];
    logic [2:0]        t4_gnt [3];
    logic [31:0]       t4_last_data;
    logic [2:0]        exp_g, prev_g;

    wfg_stim_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wfg_stim_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // SRAM model: masked byte writes, registered read data
    always @(posedge clk) begin
        if (!bus.csb0_o) begin
            if (!bus.web0_o) begin
                for (int b = 0; b < int'(DATA_W / 8); b++)
                    if (bus.wmask0_o[b]) mem[bus.addr0_o][8*b +: 8] <= bus.din0_o[8*b +: 8];
            end else begin
                bus.dout0_i <= mem[bus.addr0_o];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gnt_vec();
        return {29'd0, bus.host_gnt_o, bus.ch1_gnt_o, bus.ch0_gnt_o};
    endfunction

    function automatic logic [31:0] rvalid_vec();
        return {29'd0, bus.host_rvalid_o, bus.ch1_rvalid_o, bus.ch0_rvalid_o};
    endfunction

    task automatic set_ch(input logic r0, input logic [9:0] a0, input logic r1, input logic [9:0] a1);
        bus.ch0_req_i  = r0;
        bus.ch0_addr_i = a0;
        bus.ch1_req_i  = r1;
        bus.ch1_addr_i = a1;
    endtask

    task automatic set_host(input logic r, input logic we, input logic [9:0] a,
                            input logic [31:0] wd, input logic [3:0] wm);
        bus.host_req_i   = r;
        bus.host_we_i    = we;
        bus.host_addr_i  = a;
        bus.host_wdata_i = wd;
        bus.host_wmask_i = wm;
    endtask

    task automatic idle_all();
        set_ch(1'b0, 10'h000, 1'b0, 10'h000);
        set_host(1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
`ifdef WFG_MEM_ARB_HOST_PRIO_EN
        t4_req = '{3'b111, 3'b011, 3'b010};
        t4_gnt = '{3'b100, 3'b001, 3'b010};
        t4_last_data = 32'h3131_3131;
`else
        t4_req = '{3'b111, 3'b110, 3'b100};
        t4_gnt = '{3'b001, 3'b010, 3'b100};
        t4_last_data = 32'h3232_3232;
`endif
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[10'h010] = 32'h1234_5678;
        mem[10'h020] = 32'hA0A0_A0A0;
        mem[10'h021] = 32'hB1B1_B1B1;
        mem[10'h030] = 32'h3030_3030;
        mem[10'h031] = 32'h3131_3131;
        mem[10'h032] = 32'h3232_3232;
        bus.dout0_i = '0;

        // Reset with every requester active: nothing granted, SRAM idle
        rst_n = 1'b0;
        set_ch(1'b1, 10'h010, 1'b1, 10'h021);
        set_host(1'b1, 1'b1, 10'h3FF, 32'hFFFF_FFFF, 4'hF);
        #1;
        check("rst_gnt", gnt_vec(), 32'h0);
        check("rst_csb", 32'(bus.csb0_o), 32'h1);
        check("rst_web", 32'(bus.web0_o), 32'h1);
        check("rst_addr", 32'(bus.addr0_o), 32'h0);
        check("rst_din", bus.din0_o, 32'h0);
        check("rst_wmask", 32'(bus.wmask0_o), 32'h0);
        check("rst_rvalid", rvalid_vec(), 32'h0);
        check("rst_rdata", bus.ch0_rdata_o | bus.ch1_rdata_o | bus.host_rdata_o, 32'h0);

        // Single ch0 read in the first cycle after release
        @(negedge clk);
        rst_n = 1'b1;
        idle_all();
        set_ch(1'b1, 10'h010, 1'b0, 10'h000);
        #1;
        check("ch0_gnt", gnt_vec(), 32'h1);
        check("ch0_csb", 32'(bus.csb0_o), 32'h0);
        check("ch0_web", 32'(bus.web0_o), 32'h1);
        check("ch0_addr", 32'(bus.addr0_o), 32'h010);
        @(negedge clk);
        idle_all();
        #1;
        check("ch0_rvalid", rvalid_vec(), 32'h1);
        check("ch0_rdata", bus.ch0_rdata_o, 32'h1234_5678);
        check("ch0_other_rdata", bus.ch1_rdata_o | bus.host_rdata_o, 32'h0);
        check("idle_csb", 32'(bus.csb0_o), 32'h1);
        check("idle_addr", 32'(bus.addr0_o), 32'h0);

        // Both channels continuously: alternate ch0/ch1, rvalid routed to its source
        @(negedge clk);
        do_reset();
        prev_g = 3'b000;
        for (int i = 0; i < 4; i++) begin
            set_ch(1'b1, 10'h020, 1'b1, 10'h021);
            #1;
            exp_g = (i % 2 == 0) ? 3'b001 : 3'b010;
            check($sformatf("rr_gnt%0d", i), gnt_vec(), 32'(exp_g));
            check($sformatf("rr_addr%0d", i), 32'(bus.addr0_o), (i % 2 == 0) ? 32'h020 : 32'h021);
            check($sformatf("rr_rvalid%0d", i), rvalid_vec(), 32'(prev_g));
            if (i > 0) begin
                check($sformatf("rr_ch0_rdata%0d", i), bus.ch0_rdata_o,
                      (prev_g == 3'b001) ? 32'hA0A0_A0A0 : 32'h0);
                check($sformatf("rr_ch1_rdata%0d", i), bus.ch1_rdata_o,
                      (prev_g == 3'b010) ? 32'hB1B1_B1B1 : 32'h0);
            end
            prev_g = exp_g;
            @(negedge clk);
        end
        idle_all();
        #1;
        check("rr_last_rvalid", rvalid_vec(), 32'h2);
        check("rr_last_rdata", bus.ch1_rdata_o, 32'hB1B1_B1B1);
        check("rr_last_ch0_rdata", bus.ch0_rdata_o, 32'h0);

        // Host masked write at the top address, then read back
        @(negedge clk);
        set_host(1'b1, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 4'b0011);
        #1;
        check("hw_gnt", gnt_vec(), 32'h4);
        check("hw_csb", 32'(bus.csb0_o), 32'h0);
        check("hw_web", 32'(bus.web0_o), 32'h0);
        check("hw_addr", 32'(bus.addr0_o), 32'h3FF);
        check("hw_din", bus.din0_o, 32'hDEAD_BEEF);
        check("hw_wmask", 32'(bus.wmask0_o), 32'h3);
        @(negedge clk);
        set_host(1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0);
        #1;
        check("hw_no_rvalid", rvalid_vec(), 32'h0);
        check("hr_gnt", gnt_vec(), 32'h4);
        check("hr_web", 32'(bus.web0_o), 32'h1);
        check("hr_din", bus.din0_o, 32'h0);
        check("hr_wmask", 32'(bus.wmask0_o), 32'h0);
        @(negedge clk);
        idle_all();
        #1;
        check("hr_rvalid", rvalid_vec(), 32'h4);
        check("hr_rdata", bus.host_rdata_o, 32'h0000_BEEF);

        // All three requesting; each drops its request once granted
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_ch(t4_req[i][0], 10'h030, t4_req[i][1], 10'h031);
            set_host(t4_req[i][2], 1'b0, 10'h032, 32'h0, 4'h0);
            #1;
            check($sformatf("all_gnt%0d", i), gnt_vec(), 32'(t4_gnt[i]));
            check($sformatf("all_rvalid%0d", i), rvalid_vec(), (i == 0) ? 32'h0 : 32'(t4_gnt[i-1]));
            @(negedge clk);
        end
        idle_all();
        #1;
        check("all_last_rvalid", rvalid_vec(), 32'(t4_gnt[2]));
        check("all_last_rdata", bus.ch0_rdata_o | bus.ch1_rdata_o | bus.host_rdata_o, t4_last_data);

        // Reset the cycle after a ch1 grant: read discarded
        @(negedge clk);
        set_ch(1'b0, 10'h000, 1'b1, 10'h021);
        #1;
        check("r1_gnt", gnt_vec(), 32'h2);
        @(negedge clk);
        rst_n = 1'b0;
        idle_all();
        set_ch(1'b1, 10'h020, 1'b0, 10'h000);
        #1;
        check("r1_rvalid", rvalid_vec(), 32'h0);
        check("r1_rdata", bus.ch1_rdata_o, 32'h0);
        check("r1_csb", 32'(bus.csb0_o), 32'h1);
        check("r1_gnt_in_rst", gnt_vec(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ch(1'b1, 10'h020, 1'b1, 10'h021);
        #1;
        check("r1_post_rvalid", rvalid_vec(), 32'h0);
        check("r1_post_gnt", gnt_vec(), 32'h1);
        @(negedge clk);
        idle_all();
        #1;
        check("r1_post_rdata", bus.ch0_rdata_o, 32'hA0A0_A0A0);

        // Reset after a ch0 grant: pointer must return to ch0
        @(negedge clk);
        set_ch(1'b1, 10'h010, 1'b0, 10'h000);
        #1;
        check("r0_gnt", gnt_vec(), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        idle_all();
        #1;
        check("r0_rvalid", rvalid_vec(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ch(1'b1, 10'h020, 1'b1, 10'h021);
        #1;
        check("r0_post_gnt", gnt_vec(), 32'h1);
        @(negedge clk);
        idle_all();
        #1;
        check("r0_post_rvalid", rvalid_vec(), 32'h1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
